// File: rtl/relogio_pkg.sv
// Shared types and helpers for the relogio_alarme_core clock/alarm slice.
// Optional snooze support is selected with the RELOGIO_SNOOZE_EN macro.
package relogio_pkg;

    // Adjust/alarm mode encoding, visible on modo_ajuste
    typedef enum logic [2:0] {
        MODO_RUN     = 3'd0,
        MODO_AJ_HORA = 3'd1,
        MODO_AJ_MIN  = 3'd2,
        MODO_AJ_SEG  = 3'd3,
        MODO_AL_HORA = 3'd4,
        MODO_AL_MIN  = 3'd5
    } modo_t;

    localparam logic [5:0] SEG_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Step a field by one in either direction, wrapping between 0 and max.
    // dir = 1 increments, dir = 0 decrements. No carry is produced.
    function automatic logic [5:0] wrap_inc_dec(
        input logic [5:0] value,
        input logic [5:0] max,
        input logic       dir
    );
        logic [5:0] res;
        if (dir) begin
            res = (value >= max) ? 6'd0 : value + 6'd1;
        end else begin
            res = (value == 6'd0) ? max : value - 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/relogio_prescaler.sv
// Divides the system clock down to a one-cycle-per-second tick.
// The count is forced to zero while hold is high (time frozen during
// adjust) and can be cleared when the seconds field is edited.
module relogio_prescaler #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic tick_1hz
);

    localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] count;

    // Free-running divider with hold/clear and wrap at the terminal count
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            count <= '0;
        end else if (hold || clear) begin
            count <= '0;
        end else if (count == TERM) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // The tick is the terminal-count cycle itself; suppressed while frozen
    assign tick_1hz = (count == TERM) && !hold;

endmodule

// File: rtl/relogio_alarme_core.sv
// Timekeeping core with button-driven adjust FSM, settable alarm with
// arming, ring timeout and (optionally) snooze.
// Optional feature macro: RELOGIO_SNOOZE_EN (btn_dec while ringing snoozes).
module relogio_alarme_core #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int HORAS_DIA       = 24,
    parameter int ALARM_TIMEOUT_S = 60,
    parameter int SNOOZE_MIN      = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic [5:0] al_minutos,
    output logic [5:0] al_horas,
    output logic [2:0] modo_ajuste,
    output logic       alarme_armado,
    output logic       alarme_ativo,
    output logic       tick_1hz
);
    import relogio_pkg::*;

    localparam logic [5:0]     HORA_MAX = 6'(HORAS_DIA - 1);
    localparam int             TOW      = (ALARM_TIMEOUT_S > 1) ? $clog2(ALARM_TIMEOUT_S) : 1;
    localparam logic [TOW-1:0] TO_LAST  = TOW'(ALARM_TIMEOUT_S - 1);

    // State registers and their next values
    logic [5:0]     seg_cnt, seg_n;
    logic [5:0]     min_cnt, min_n;
    logic [5:0]     hora_cnt, hora_n;
    logic [5:0]     al_min, al_min_n;
    logic [5:0]     al_hora, al_hora_n;
    modo_t          modo, modo_n;
    logic           armado, armado_n;
    logic           ativo, ativo_n;
    logic [TOW-1:0] to_cnt, to_n;

`ifdef RELOGIO_SNOOZE_EN
    localparam int            SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int            SW           = $clog2(SNOOZE_TICKS + 1);
    localparam logic [SW-1:0] SNOOZE_LOAD  = SW'(SNOOZE_TICKS);
    logic [SW-1:0] snz_cnt, snz_n;
    logic          snoozing, snoozing_n;
`endif

    // Decoded button actions: only the highest-priority pulse acts
    logic act_inc, act_dec, any_btn;
    logic hold_pre, clear_pre, modo_conta;
    logic consumed, alarm_match;

    assign act_inc    = btn_inc && !btn_mode;
    assign act_dec    = btn_dec && !btn_mode && !btn_inc;
    assign any_btn    = btn_mode || btn_inc || btn_dec;
    assign hold_pre   = (modo == MODO_AJ_HORA) || (modo == MODO_AJ_MIN) || (modo == MODO_AJ_SEG);
    assign modo_conta = (modo == MODO_RUN) || (modo == MODO_AL_HORA) || (modo == MODO_AL_MIN);
    assign clear_pre  = (modo == MODO_AJ_SEG) && (act_inc || act_dec) && !consumed;

    relogio_prescaler #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_prescaler (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .hold      (hold_pre),
        .clear     (clear_pre),
        .tick_1hz  (tick_1hz)
    );

    // Next-state logic: timebase carry chain, mode/field edits, alarm ring
    always_comb begin
        seg_n       = seg_cnt;
        min_n       = min_cnt;
        hora_n      = hora_cnt;
        al_min_n    = al_min;
        al_hora_n   = al_hora;
        modo_n      = modo;
        armado_n    = armado;
        ativo_n     = ativo;
        to_n        = to_cnt;
        alarm_match = 1'b0;
        consumed    = 1'b0;
`ifdef RELOGIO_SNOOZE_EN
        snz_n       = snz_cnt;
        snoozing_n  = snoozing;
`endif

        // Full carry chain resolves in one cycle (23:59:59 -> 00:00:00)
        if (tick_1hz) begin
            seg_n = wrap_inc_dec(seg_cnt, SEG_MAX, 1'b1);
            if (seg_cnt == SEG_MAX) begin
                min_n = wrap_inc_dec(min_cnt, MIN_MAX, 1'b1);
                if (min_cnt == MIN_MAX) begin
                    hora_n = wrap_inc_dec(hora_cnt, HORA_MAX, 1'b1);
                end else begin
                    hora_n = hora_cnt;
                end
            end else begin
                min_n = min_cnt;
            end
        end else begin
            seg_n = seg_cnt;
        end

        alarm_match = tick_1hz && armado && modo_conta && (seg_n == 6'd0) &&
                      (min_n == al_min) && (hora_n == al_hora);

        // A pulse that dismisses a ring (or cancels a snooze) does nothing else
`ifdef RELOGIO_SNOOZE_EN
        consumed = (ativo && any_btn) || (snoozing && (btn_mode || btn_inc));
`else
        consumed = ativo && any_btn;
`endif

        if (consumed) begin
            modo_n = modo;
        end else if (btn_mode) begin
            case (modo)
                MODO_RUN:     modo_n = MODO_AJ_HORA;
                MODO_AJ_HORA: modo_n = MODO_AJ_MIN;
                MODO_AJ_MIN:  modo_n = MODO_AJ_SEG;
                MODO_AJ_SEG:  modo_n = MODO_AL_HORA;
                MODO_AL_HORA: modo_n = MODO_AL_MIN;
                MODO_AL_MIN:  modo_n = MODO_RUN;
                default:      modo_n = MODO_RUN;
            endcase
        end else if (act_inc || act_dec) begin
            case (modo)
                MODO_RUN:     armado_n  = act_inc ? !armado : armado;
                MODO_AJ_HORA: hora_n    = wrap_inc_dec(hora_cnt, HORA_MAX, act_inc);
                MODO_AJ_MIN:  min_n     = wrap_inc_dec(min_cnt, MIN_MAX, act_inc);
                MODO_AJ_SEG:  seg_n     = wrap_inc_dec(seg_cnt, SEG_MAX, act_inc);
                MODO_AL_HORA: al_hora_n = wrap_inc_dec(al_hora, HORA_MAX, act_inc);
                MODO_AL_MIN:  al_min_n  = wrap_inc_dec(al_min, MIN_MAX, act_inc);
                default:      modo_n    = MODO_RUN;
            endcase
        end else begin
            modo_n = modo;
        end

        // Ring: dismiss on any pulse, otherwise time out after N ticks
        if (ativo) begin
            if (any_btn) begin
                ativo_n = 1'b0;
            end else if (tick_1hz) begin
                if (to_cnt == TO_LAST) begin
                    ativo_n = 1'b0;
                end else begin
                    to_n = to_cnt + TOW'(1);
                end
            end else begin
                ativo_n = ativo;
            end
        end else if (alarm_match) begin
            ativo_n = 1'b1;
            to_n    = '0;
        end else begin
            ativo_n = ativo;
        end

`ifdef RELOGIO_SNOOZE_EN
        // Snooze: btn_dec while ringing defers the ring by SNOOZE_MIN minutes
        if (ativo && act_dec) begin
            snoozing_n = 1'b1;
            snz_n      = SNOOZE_LOAD;
        end else if (snoozing) begin
            if (btn_mode || btn_inc) begin
                snoozing_n = 1'b0;
            end else if (tick_1hz) begin
                if (snz_cnt <= SW'(1)) begin
                    snoozing_n = 1'b0;
                    snz_n      = '0;
                    ativo_n    = 1'b1;
                    to_n       = '0;
                end else begin
                    snz_n = snz_cnt - SW'(1);
                end
            end else begin
                snoozing_n = snoozing;
            end
        end else begin
            snoozing_n = snoozing;
        end
`endif
    end

    // State register with synchronous reset to RUN and all-zero time/alarm
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            seg_cnt  <= 6'd0;
            min_cnt  <= 6'd0;
            hora_cnt <= 6'd0;
            al_min   <= 6'd0;
            al_hora  <= 6'd0;
            modo     <= MODO_RUN;
            armado   <= 1'b0;
            ativo    <= 1'b0;
            to_cnt   <= '0;
`ifdef RELOGIO_SNOOZE_EN
            snz_cnt  <= '0;
            snoozing <= 1'b0;
`endif
        end else begin
            seg_cnt  <= seg_n;
            min_cnt  <= min_n;
            hora_cnt <= hora_n;
            al_min   <= al_min_n;
            al_hora  <= al_hora_n;
            modo     <= modo_n;
            armado   <= armado_n;
            ativo    <= ativo_n;
            to_cnt   <= to_n;
`ifdef RELOGIO_SNOOZE_EN
            snz_cnt  <= snz_n;
            snoozing <= snoozing_n;
`endif
        end
    end

    assign segundos      = seg_cnt;
    assign minutos       = min_cnt;
    assign horas         = hora_cnt;
    assign al_minutos    = al_min;
    assign al_horas      = al_hora;
    assign modo_ajuste   = modo;
    assign alarme_armado = armado;
    assign alarme_ativo  = ativo;

endmodule

// File: tb/tb_relogio_alarme_core.sv
// Directed self-checking bench for relogio_alarme_core.
// Main DUT: 10 Hz clock, 24 h, 3 s timeout, 1 min snooze.
// Second DUT (same stimulus): 12 h day, used for the hour-wrap check.
`timescale 1ns/1ps
module tb_relogio_alarme_core;

    logic clk_100MHz = 1'b0;
    logic reset;
    logic btn_mode, btn_inc, btn_dec;

    logic [5:0] segundos, minutos, horas, al_minutos, al_horas;
    logic [2:0] modo_ajuste;
    logic       alarme_armado, alarme_ativo, tick_1hz;

    logic [5:0] b_segundos, b_minutos, b_horas, b_al_minutos, b_al_horas;
    logic [2:0] b_modo_ajuste;
    logic       b_alarme_armado, b_alarme_ativo, b_tick_1hz;

    int checks = 0;
    int errors = 0;

    relogio_alarme_core #(
        .CLK_FREQ_HZ(10), .HORAS_DIA(24), .ALARM_TIMEOUT_S(3), .SNOOZE_MIN(1)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .al_minutos(al_minutos), .al_horas(al_horas), .modo_ajuste(modo_ajuste),
        .alarme_armado(alarme_armado), .alarme_ativo(alarme_ativo), .tick_1hz(tick_1hz)
    );

    relogio_alarme_core #(
        .CLK_FREQ_HZ(10), .HORAS_DIA(12), .ALARM_TIMEOUT_S(3), .SNOOZE_MIN(1)
    ) dut12 (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .segundos(b_segundos), .minutos(b_minutos), .horas(b_horas),
        .al_minutos(b_al_minutos), .al_horas(b_al_horas), .modo_ajuste(b_modo_ajuste),
        .alarme_armado(b_alarme_armado), .alarme_ativo(b_alarme_ativo), .tick_1hz(b_tick_1hz)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        wait_cycle();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_h"}, 32'(horas), 32'(h));
        chk({tag, "_m"}, 32'(minutos), 32'(m));
        chk({tag, "_s"}, 32'(segundos), 32'(s));
    endtask

    // Advance until the current cycle carries tick_1hz (bounded)
    task automatic wait_tick(input string tag);
        int n = 0;
        while (tick_1hz !== 1'b1 && n < 40) begin
            wait_cycle();
            n++;
        end
        chk(tag, 32'(tick_1hz), 32'd1);
    endtask

    // Advance until alarme_ativo rises (bounded)
    task automatic wait_ring(input string tag);
        int n = 0;
        while (alarme_ativo !== 1'b1 && n < 1000) begin
            wait_cycle();
            n++;
        end
        chk(tag, 32'(alarme_ativo), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_time(tag, 0, 0, 0);
        chk({tag, "_alm"}, 32'(al_minutos), 32'd0);
        chk({tag, "_alh"}, 32'(al_horas), 32'd0);
        chk({tag, "_modo"}, 32'(modo_ajuste), 32'd0);
        chk({tag, "_arm"}, 32'(alarme_armado), 32'd0);
        chk({tag, "_ativo"}, 32'(alarme_ativo), 32'd0);
        chk({tag, "_tick"}, 32'(tick_1hz), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (3) wait_cycle();
        check_reset_state("rst");
        chk("rst_b_h", 32'(b_horas), 32'd0);
        reset = 1'b0;

        // 1. Free run: tick every 10th cycle, one minute after 600 cycles
        for (int k = 0; k < 600; k++) begin
            chk("tick_pattern", 32'(tick_1hz), (k % 10 == 9) ? 32'd1 : 32'd0);
            if (k == 599) chk("seg_at_599", 32'(segundos), 32'd59);
            wait_cycle();
        end
        check_time("run600", 0, 1, 0);

        // 2/3. Preload 23:59:59 (11:59:59 on 12 h DUT) through decrement wraps
        press(1'b1, 1'b0, 1'b0);
        chk("modo_aj_hora", 32'(modo_ajuste), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        chk("hora_wrap24", 32'(horas), 32'd23);
        chk("hora_wrap12", 32'(b_horas), 32'd11);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("min_dec_1to0", 32'(minutos), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        chk("min_dec_wrap", 32'(minutos), 32'd59);
        chk("min_dec_hora_kept", 32'(horas), 32'd23);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("seg_dec_wrap", 32'(segundos), 32'd59);
        for (int k = 0; k < 50; k++) begin
            chk("frozen_no_tick", 32'(tick_1hz), 32'd0);
            wait_cycle();
        end
        chk("frozen_seg", 32'(segundos), 32'd59);
        repeat (3) press(1'b1, 1'b0, 1'b0);
        chk("back_to_run", 32'(modo_ajuste), 32'd0);
        check_time("pre_wrap", 23, 59, 59);
        chk("pre_wrap_b_h", 32'(b_horas), 32'd11);
        wait_tick("wrap_tick");
        wait_cycle();
        check_time("day_wrap", 0, 0, 0);
        chk("day_wrap_b_h", 32'(b_horas), 32'd0);
        chk("day_wrap_b_m", 32'(b_minutos), 32'd0);
        chk("day_wrap_b_s", 32'(b_segundos), 32'd0);

        // 4. Alarm 00:02, armed, start 00:01:58
        reset = 1'b1;
        wait_cycle();
        reset = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("modo_al_min", 32'(modo_ajuste), 32'd5);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("al_min_set", 32'(al_minutos), 32'd2);
        chk("al_hora_set", 32'(al_horas), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("armed", 32'(alarme_armado), 32'd1);
        check_time("start_0158", 0, 1, 58);
        wait_tick("tick_0159");
        wait_cycle();
        check_time("t_0159", 0, 1, 59);
        wait_tick("tick_0200");
        chk("ring_not_yet", 32'(alarme_ativo), 32'd0);
        wait_cycle();
        chk("ring_on", 32'(alarme_ativo), 32'd1);
        check_time("ring_time", 0, 2, 0);
        for (int t = 1; t <= 3; t++) begin
            wait_tick("timeout_tick");
            wait_cycle();
            chk("timeout_ring", 32'(alarme_ativo), (t < 3) ? 32'd1 : 32'd0);
        end
        chk("timeout_armed", 32'(alarme_armado), 32'd1);

        // 4b. Dismiss with btn_inc at 00:03:00
        repeat (5) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("al_min_3", 32'(al_minutos), 32'd3);
        wait_ring("ring_0300");
        check_time("ring_0300", 0, 3, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("dismiss_ativo", 32'(alarme_ativo), 32'd0);
        chk("dismiss_armed", 32'(alarme_armado), 32'd1);
        chk("dismiss_modo", 32'(modo_ajuste), 32'd0);

        // 5. Simultaneous mode+inc in RUN: mode wins
        press(1'b1, 1'b1, 1'b0);
        chk("prio_modo", 32'(modo_ajuste), 32'd1);
        chk("prio_armed", 32'(alarme_armado), 32'd1);

        // 6. Ring at 00:04, btn_dec while ringing
        repeat (4) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("al_min_4", 32'(al_minutos), 32'd4);
        wait_ring("ring_0400");
        press(1'b0, 1'b0, 1'b1);
        chk("dec_clears", 32'(alarme_ativo), 32'd0);
`ifdef RELOGIO_SNOOZE_EN
        for (int t = 1; t <= 60; t++) begin
            wait_tick("snooze_tick");
            wait_cycle();
            chk("snooze_ring", 32'(alarme_ativo), (t == 60) ? 32'd1 : 32'd0);
        end
`else
        for (int t = 1; t <= 60; t++) begin
            wait_tick("nosnooze_tick");
            wait_cycle();
            chk("nosnooze_quiet", 32'(alarme_ativo), 32'd0);
        end
        repeat (5) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("al_min_6", 32'(al_minutos), 32'd6);
        wait_ring("ring_0600");
`endif

        // 5b. Reset while ringing returns everything to zero
        chk("pre_reset_ring", 32'(alarme_ativo), 32'd1);
        reset = 1'b1;
        wait_cycle();
        check_reset_state("rst_ring");
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/relogio_alarme_core.md
Name: relogio_alarme_core

Overview:
- Parametrised timekeeping core: second/minute/hour counters with configurable clock rate and day length.
- Button-driven adjust FSM covers time and a settable alarm; alarm output has a timeout.
- Consumes single-cycle, already-debounced button pulses; drives the display block and LEDs in the Nexys top.
- Successor to the fixed 3-mode clock core; adds alarm modes, arming, seconds adjust and parametrised limits.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock cycles per second (prescaler terminal count).
- HORAS_DIA, 24, hour modulus (12 or 24); horas counts 0..HORAS_DIA-1.
- ALARM_TIMEOUT_S, 60, seconds alarme_ativo stays high if not dismissed.
- SNOOZE_MIN, 5, snooze length in minutes (used only with the optional feature).

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse: advance mode
- btn_inc  in  1  one-cycle pulse: increment field / toggle alarm arm in RUN
- btn_dec  in  1  one-cycle pulse: decrement field / snooze (optional)
- segundos  out  6  current seconds 0..59
- minutos  out  6  current minutes 0..59
- horas  out  6  current hours 0..HORAS_DIA-1
- al_minutos  out  6  alarm minute
- al_horas  out  6  alarm hour
- modo_ajuste  out  3  current mode encoding
- alarme_armado  out  1  alarm enabled
- alarme_ativo  out  1  alarm ringing
- tick_1hz  out  1  one-cycle pulse per elapsed second

Behaviour:
- Interface: one clock (clk_100MHz); reset is synchronous, active-high.
- Reset: all outputs 0; mode RUN; prescaler 0.
- Prescaler: counts 0..CLK_FREQ_HZ-1, width $clog2(CLK_FREQ_HZ).
  - tick_1hz=1 in the cycle the count equals CLK_FREQ_HZ-1; the count then wraps to 0.
  - Held at 0 in AJ_HORA/AJ_MIN/AJ_SEG, so time is frozen while adjusting.
- Counting on tick: seg 59→0 carries to min; min 59→0 carries to hour; hour HORAS_DIA-1→0. All carries resolve in the same cycle, so 23:59:59 becomes 00:00:00 in one step.
- FSM modes (modo_ajuste): RUN=0, AJ_HORA=1, AJ_MIN=2, AJ_SEG=3, AL_HORA=4, AL_MIN=5.
  - btn_mode advances 0→1→…→5→0.
  - Time keeps counting in AL_* modes.
- Adjust: btn_inc/btn_dec modify the selected field by ±1 with wrap and no carry (59+1→0, 0-1→59; hours 0-1→HORAS_DIA-1).
  - Update is visible the cycle after the pulse.
  - In AJ_SEG, any edit also clears the prescaler.
- RUN: btn_inc toggles alarme_armado; btn_dec has no effect (unless optional feature).
- Alarm trigger: in RUN or AL_* with alarme_armado=1, at the tick where the new time equals al_horas:al_minutos:00, alarme_ativo←1 on the following cycle.
- Alarm clear: while alarme_ativo=1, the first button pulse of any kind clears it and is consumed (no mode/field/arm effect). Otherwise it auto-clears after ALARM_TIMEOUT_S ticks.
- Simultaneous pulses in one cycle: priority mode > inc > dec; only one acts.
- Reset mid-alarm or mid-adjust: immediate return to reset state; the alarm time is also cleared.

Optional Feature:
- RELOGIO_SNOOZE_EN defined: btn_dec while alarme_ativo=1 clears alarme_ativo and loads a snooze counter with SNOOZE_MIN*60.
  - The counter decrements on each tick; when it reaches 0, alarme_ativo re-asserts.
  - Any btn_mode/btn_inc pulse while snoozing cancels the snooze; that pulse is consumed.
- Undefined: btn_dec simply dismisses like any button; no snooze logic is synthesised.

Decomposition:
- Package relogio_pkg:
  - modo_t enum (3-bit, values above).
  - constants SEG_MAX=59, MIN_MAX=59.
  - function wrap_inc_dec(value, max, dir).
- Sub-module relogio_prescaler:
  - Parameter CLK_FREQ_HZ; inputs clk_100MHz, reset, hold, clear; output tick_1hz.
  - Instantiated once.

Test Plan:
1. CLK_FREQ_HZ=10: release reset, run 600 cycles → tick_1hz every 10th cycle; segundos=59 at cycle 599; 00:01:00 after cycle 600.
2. Preload 23:59:59 via adjust, return to RUN, wait one tick → 00:00:00. Repeat with HORAS_DIA=12 from 11:59:59 → 00:00:00.
3. Mode AJ_MIN, min=0, btn_dec → 59, hours unchanged. Hold 50 cycles → segundos unchanged and no tick_1hz.
4. Alarm 00:02, armed, start 00:01:58 → alarme_ativo=1 one cycle after the 00:02:00 tick. With ALARM_TIMEOUT_S=3 and no press → clears after the 3rd tick. Repeat with btn_inc press → clears, alarme_armado stays 1.
5. btn_mode and btn_inc asserted in the same cycle in RUN → modo_ajuste=1, alarme_armado unchanged. Reset asserted while alarme_ativo=1 → all outputs 0 next cycle.
6. With RELOGIO_SNOOZE_EN, SNOOZE_MIN=1: btn_dec while ringing → alarme_ativo=0, re-asserts exactly 60 ticks later. Without the macro → stays 0.
